lcd_bus_driver: RTL and testbench
=================================

Name: lcd_bus_driver

Overview:
- Timing and initialisation engine for an HD44780-compatible character LCD in 8-bit, write-only mode.
- Sits directly downstream of the LCD text/CRC writer: the writer hands it one byte plus RS per transfer over a valid/ready handshake.
- The block owns all LCD pin timing: the power-up wait, the fixed init command sequence, EN pulse generation and per-command execution delays.

Parameters:
- PWRUP_CYC, 1000000: cycles in PWRUP after reset release (20 ms at 50 MHz).
- SETUP_CYC, 2: cycles RS/DATA are stable with EN low before the EN rise.
- EN_CYC, 25: cycles EN is held high.
- CMD_CYC, 2500: post-pulse execution wait for normal commands and characters (50 us).
- CLR_CYC, 82000: post-pulse wait for clear/home and for the first init command (1.64 ms).
- CNT_W, 21: delay counter width. Must hold the largest of the cycle parameters.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- IN_VALID  in  1  the writer presents a byte.
- IN_READY  out  1  the block accepts a byte this cycle.
- IN_RS  in  1  0 = command, 1 = character data.
- IN_DATA  in  8  byte to write.
- INIT_DONE  out  1  the init sequence has completed; stays high until the next reset.
- LCD_RS  out  1  LCD register select.
- LCD_RW  out  1  constant 0 (write only).
- LCD_EN  out  1  LCD enable strobe.
- LCD_DATA  out  8  LCD data bus.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high. All outputs are registered.
- Reset values: LCD_EN=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, IN_READY=0, INIT_DONE=0, state=PWRUP, init index=0.
- Reset mid-operation (any state, including EN high): on the next edge all outputs return to their reset values and the init sequence restarts from PWRUP. A partial transfer is abandoned.
- States: PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, WAIT.
- PWRUP: lasts exactly PWRUP_CYC cycles. Cycle 0 is the first cycle with Reset low. Then goes to INIT_LOAD.
- INIT_LOAD: zero-cycle decision. It loads ROM[idx] with RS=0 and goes to SETUP in the same cycle the PWRUP count expires, or the same cycle the previous WAIT expires. It adds no cycles.
- Init ROM, 6 entries in order: 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
- SETUP: LCD_RS/LCD_DATA driven from the latched byte, LCD_EN=0, for SETUP_CYC cycles.
- PULSE: LCD_EN=1 for EN_CYC cycles. RS/DATA stay unchanged.
- WAIT: LCD_EN=0 for the wait count, then:
  - during init with idx<5: INIT_LOAD with idx+1;
  - after init entry 5: IDLE, and INIT_DONE goes high;
  - otherwise: IDLE.
- Wait selection: CLR_CYC if the init index is 0, or if RS=0 and the byte is 0x01 or 0x02. Otherwise CMD_CYC. A byte 0x01 sent with RS=1 uses CMD_CYC.
- IDLE: IN_READY=1 only here, and only when INIT_DONE=1. IN_READY is low in every other state and throughout init.
- Accept: on a cycle T with IN_VALID and IN_READY both high, IN_RS/IN_DATA are latched. Then:
  - SETUP occupies T+1 .. T+SETUP_CYC;
  - PULSE follows for EN_CYC cycles;
  - WAIT follows for the selected wait count;
  - IDLE with IN_READY=1 at T+1+SETUP_CYC+EN_CYC+wait.
- No back-pressure bypass: at most one byte is in flight. Input changes during a transfer are ignored.
- LCD_RS/LCD_DATA hold their last values in IDLE.
- Counter: a single down-counter, loaded with N-1 on state entry. The state advances when it reaches 0.

Decomposition:
- Shared package lcd_pkg holds:
  - command constants LCD_FUNC_8B2L=0x38, LCD_DISP_ON=0x0C, LCD_CLEAR=0x01, LCD_HOME=0x02, LCD_ENTRY_INC=0x06;
  - INIT_LEN=6;
  - the state encoding.
- The init ROM is a function in lcd_pkg. The writer block uses the same constants.
- One sub-module: lcd_delay_timer. It is a loadable down-counter of width CNT_W, with load/value inputs and a done pulse output.

Test Plan:
- Parameter overrides for all scenarios: PWRUP=10, SETUP=2, EN=3, CMD=5, CLR=8.
- Init from reset: release Reset at cycle 0 -> six EN pulses, 3 cycles each, RS=0, data 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. INIT_DONE=1 and IN_READY=1 first at cycle 76. LCD_RW=0 throughout.
- Character write: IN_VALID held from cycle 20 with RS=1, DATA=0x41 -> no accept before cycle 76. Accept at T=76, EN high 79–81 with DATA=0x41 and RS=1, IN_READY next high at 87.
- Clear vs character 0x01: RS=0, 0x01 -> IN_READY returns at T+14. RS=1, 0x01 -> IN_READY returns at T+11.
- Back-to-back: IN_VALID held with 0x41 then 0x42 -> second accept exactly at T+11. IN_DATA toggled during the first transfer does not disturb LCD_DATA while EN=1.
- Reset mid-pulse: assert Reset for 1 cycle while LCD_EN=1 -> the next cycle has EN=0, DATA=0, IN_READY=0, INIT_DONE=0. The full init repeats, with INIT_DONE at cycle 76 after release.

Source files
------------

// File: rtl/lcd_bus_driver_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 character-LCD path: command byte
// constants, the power-on init sequence (as a ROM function), the driver state
// encoding and the rule that picks the long execution wait.
// The upstream text/CRC writer imports the same command constants.
// -----------------------------------------------------------------------------
package lcd_pkg;

    // HD44780 command bytes (RS = 0)
    localparam logic [7:0] LCD_FUNC_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;  // display on, cursor off
    localparam logic [7:0] LCD_CLEAR     = 8'h01;  // clear display
    localparam logic [7:0] LCD_HOME      = 8'h02;  // return home
    localparam logic [7:0] LCD_ENTRY_INC = 8'h06;  // increment address, no shift

    localparam int INIT_LEN = 6;

    // ST_INIT_LOAD is a zero-cycle decision point: it is resolved inside the
    // next-state logic and is never held in the state register.
    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_LOAD,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_WAIT
    } lcd_state_t;

    // Init command sequence; the function-set byte is repeated three times
    // so the controller locks into 8-bit mode regardless of its prior state.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] cmd;
        case (idx)
            3'd0, 3'd1, 3'd2: cmd = LCD_FUNC_8B2L;
            3'd3:             cmd = LCD_DISP_ON;
            3'd4:             cmd = LCD_CLEAR;
            3'd5:             cmd = LCD_ENTRY_INC;
            default:          cmd = 8'h00;
        endcase
        return cmd;
    endfunction

    // Clear and home are the slow commands. A character byte that happens to
    // equal 0x01/0x02 is just a glyph and takes the normal wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == LCD_CLEAR) || (data == LCD_HOME));
    endfunction

endpackage

// File: rtl/lcd_bus_driver_if.sv
// -----------------------------------------------------------------------------
// lcd_bus_driver_if
// Byte handshake between the LCD text writer (master) and lcd_bus_driver
// (slave).
//   IN_VALID  master->slave  a byte is presented
//   IN_READY  slave->master  the driver takes the byte this cycle
//   IN_RS     master->slave  0 = command, 1 = character data
//   IN_DATA   master->slave  byte to write
// -----------------------------------------------------------------------------
interface lcd_bus_driver_if;
    logic       IN_VALID;
    logic       IN_READY;
    logic       IN_RS;
    logic [7:0] IN_DATA;

    modport master (output IN_VALID, output IN_RS, output IN_DATA, input IN_READY);
    modport slave  (input IN_VALID, input IN_RS, input IN_DATA, output IN_READY);
endinterface

// File: rtl/lcd_delay_timer.sv
// -----------------------------------------------------------------------------
// lcd_delay_timer
// Loadable down-counter used for every LCD timing interval.
//   Clock  in   system clock
//   Reset  in   synchronous active-high reset; reloads RST_VAL and arms
//   load   in   load 'value' (N-1 for an N-cycle interval) and arm
//   value  in   CNT_W-bit load value
//   done   out  one-cycle pulse in the last cycle of the loaded interval
// -----------------------------------------------------------------------------
module lcd_delay_timer #(
    parameter int               CNT_W   = 21,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             done
);

    logic [CNT_W-1:0] count_reg;
    logic             armed_reg;

    // Coming out of reset the timer is already measuring the power-up wait,
    // so the driver needs no extra cycle to start it.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count_reg <= RST_VAL;
            armed_reg <= 1'b1;
        end else if (load) begin
            count_reg <= value;
            armed_reg <= 1'b1;
        end else if (armed_reg) begin
            if (count_reg == '0) begin
                armed_reg <= 1'b0;
            end else begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Disarming after expiry keeps done a single-cycle pulse.
    assign done = armed_reg && (count_reg == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// -----------------------------------------------------------------------------
// lcd_bus_driver
// Timing and initialisation engine for an HD44780-compatible LCD, 8-bit
// write-only. Runs the power-up wait and fixed init sequence, then accepts one
// byte at a time from the text writer and drives it onto the LCD pins with
// setup, enable pulse and command execution delays.
//   Clock      in   system clock
//   Reset      in   synchronous active-high reset
//   in_bus     slave modport: IN_VALID / IN_READY / IN_RS / IN_DATA
//   INIT_DONE  out  init sequence finished; high until the next reset
//   LCD_RS     out  LCD register select
//   LCD_RW     out  tied low (write only)
//   LCD_EN     out  LCD enable strobe
//   LCD_DATA   out  LCD data bus
// -----------------------------------------------------------------------------
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC = 1000000,
    parameter int SETUP_CYC = 2,
    parameter int EN_CYC    = 25,
    parameter int CMD_CYC   = 2500,
    parameter int CLR_CYC   = 82000,
    parameter int CNT_W     = 21
) (
    input  logic                Clock,
    input  logic                Reset,
    lcd_bus_driver_if.slave     in_bus,
    output logic                INIT_DONE,
    output logic                LCD_RS,
    output logic                LCD_RW,
    output logic                LCD_EN,
    output logic [7:0]          LCD_DATA
);

    lcd_state_t       state_reg, state_next;
    logic [2:0]       idx_reg, idx_next;
    logic             rs_reg, rs_next;
    logic [7:0]       data_reg, data_next;
    logic             init_done_reg, init_done_next;
    logic             en_reg;
    logic             ready_reg;

    logic             init_load;
    logic             long_wait;
    logic             timer_load;
    logic [CNT_W-1:0] timer_value;
    logic             timer_done;

    lcd_delay_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(PWRUP_CYC - 1))
    ) u_timer (
        .Clock (Clock),
        .Reset (Reset),
        .load  (timer_load),
        .value (timer_value),
        .done  (timer_done)
    );

    // The first init command gets the long wait because the controller may
    // still be finishing its internal reset.
    assign long_wait = (!init_done_reg && (idx_reg == 3'd0)) || is_slow_cmd(rs_reg, data_reg);

    // Next-state logic. A pending init load overrides the case result so that
    // ST_INIT_LOAD costs no cycle: the ROM byte is latched on the same edge
    // that leaves PWRUP or WAIT.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        rs_next        = rs_reg;
        data_next      = data_reg;
        init_done_next = init_done_reg;
        init_load      = 1'b0;

        case (state_reg)
            ST_PWRUP: begin
                if (timer_done) begin
                    init_load = 1'b1;
                end
            end
            ST_IDLE: begin
                if (in_bus.IN_VALID && ready_reg) begin
                    rs_next    = in_bus.IN_RS;
                    data_next  = in_bus.IN_DATA;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_done) begin
                    state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (timer_done) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_done) begin
                    if (!init_done_reg && (idx_reg < 3'(INIT_LEN - 1))) begin
                        idx_next  = idx_reg + 3'd1;
                        init_load = 1'b1;
                    end else begin
                        init_done_next = 1'b1;
                        state_next     = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_PWRUP;
            end
        endcase

        if (init_load) begin
            state_next = ST_SETUP;
            rs_next    = 1'b0;
            data_next  = init_rom(idx_next);
        end
    end

    // Every timed state is entered from a different state, so a state change
    // into a timed state is exactly the "entry" that reloads the counter.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        if (state_next != state_reg) begin
            case (state_next)
                ST_SETUP: begin
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(SETUP_CYC - 1);
                end
                ST_PULSE: begin
                    timer_load  = 1'b1;
                    timer_value = CNT_W'(EN_CYC - 1);
                end
                ST_WAIT: begin
                    timer_load  = 1'b1;
                    timer_value = long_wait ? CNT_W'(CLR_CYC - 1) : CNT_W'(CMD_CYC - 1);
                end
                default: begin
                    timer_load  = 1'b0;
                    timer_value = '0;
                end
            endcase
        end
    end

    // EN and READY are registered from the next state so they line up with
    // the state register rather than lagging it by a cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg     <= ST_PWRUP;
            idx_reg       <= 3'd0;
            rs_reg        <= 1'b0;
            data_reg      <= 8'h00;
            init_done_reg <= 1'b0;
            en_reg        <= 1'b0;
            ready_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            rs_reg        <= rs_next;
            data_reg      <= data_next;
            init_done_reg <= init_done_next;
            en_reg        <= (state_next == ST_PULSE);
            ready_reg     <= (state_next == ST_IDLE) && init_done_next;
        end
    end

    // The latched byte registers drive the pins directly, so RS/DATA hold
    // their last values through IDLE.
    assign LCD_RS          = rs_reg;
    assign LCD_DATA        = data_reg;
    assign LCD_EN          = en_reg;
    assign LCD_RW          = 1'b0;
    assign INIT_DONE       = init_done_reg;
    assign in_bus.IN_READY = ready_reg;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// -----------------------------------------------------------------------------
// tb_lcd_bus_driver
// Scoreboard bench for lcd_bus_driver with shortened timing parameters.
// The stimulus side predicts, from the LCD timing rules, when each byte is
// accepted, when its EN pulse rises and when IN_READY returns, and queues
// those expectations; a monitor pops and compares as the DUT shows them.
// -----------------------------------------------------------------------------
module tb_lcd_bus_driver;

    localparam int P_PWRUP = 10;
    localparam int P_SETUP = 2;
    localparam int P_EN    = 3;
    localparam int P_CMD   = 5;
    localparam int P_CLR   = 8;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       init_done, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    always #5 Clock = ~Clock;

    lcd_bus_driver_if bus ();

    lcd_bus_driver #(
        .PWRUP_CYC (P_PWRUP),
        .SETUP_CYC (P_SETUP),
        .EN_CYC    (P_EN),
        .CMD_CYC   (P_CMD),
        .CLR_CYC   (P_CLR),
        .CNT_W     (21)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .in_bus    (bus),
        .INIT_DONE (init_done),
        .LCD_RS    (lcd_rs),
        .LCD_RW    (lcd_rw),
        .LCD_EN    (lcd_en),
        .LCD_DATA  (lcd_data)
    );

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } pulse_t;

    pulse_t pulse_q[$];
    int     accept_q[$];
    int     ready_q[$];
    int     done_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_now = 0;     // cycle index; 0 = first cycle with Reset low
    int model_ready = 0; // predicted first cycle with IN_READY high
    int n_pulse = 0;

    always @(posedge Clock) cyc_now <= Reset ? 0 : cyc_now + 1;

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc_now);
        end
    endtask

    function automatic int wait_of(input logic rs, input logic [7:0] d, input bit first_init);
        if (first_init || (!rs && (d == 8'h01 || d == 8'h02))) return P_CLR;
        return P_CMD;
    endfunction

    // Expected init pulses, computed from the command list and delay rules.
    task automatic push_init();
        logic [7:0] rom [6];
        int         start;
        pulse_t     p;
        rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        start = P_PWRUP;
        for (int i = 0; i < 6; i++) begin
            p.rs = 1'b0; p.data = rom[i]; p.rise = start + P_SETUP;
            pulse_q.push_back(p);
            start += P_SETUP + P_EN + wait_of(1'b0, rom[i], i == 0);
        end
        done_q.push_back(start);
        ready_q.push_back(start);
        model_ready = start;
    endtask

    task automatic check_reset_values();
        check("rst_lcd_en", int'(lcd_en), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_rw", int'(lcd_rw), 0);
        check("rst_lcd_data", int'(lcd_data), 0);
        check("rst_in_ready", int'(bus.IN_READY), 0);
        check("rst_init_done", int'(init_done), 0);
    endtask

    // Called just after a rising edge; leaves IN_VALID low just after the
    // rising edge that follows the handshake.
    task automatic send(input logic rs, input logic [7:0] d);
        int     v, t;
        bit     got;
        pulse_t p;
        v = cyc_now;
        bus.IN_VALID = 1'b1;
        bus.IN_RS    = rs;
        bus.IN_DATA  = d;
        t = (v > model_ready) ? v : model_ready;
        accept_q.push_back(t);
        p.rs = rs; p.data = d; p.rise = t + 1 + P_SETUP;
        pulse_q.push_back(p);
        model_ready = t + 1 + P_SETUP + P_EN + wait_of(rs, d, 1'b0);
        ready_q.push_back(model_ready);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge Clock);
            if (bus.IN_READY) got = 1'b1;
        end
        check("handshake_seen", int'(got), 1);
        @(posedge Clock); #1;
        bus.IN_VALID = 1'b0;
        bus.IN_RS    = 1'($urandom_range(0, 1));
        bus.IN_DATA  = 8'($urandom);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge Clock); #1;
            bus.IN_RS   = 1'($urandom_range(0, 1));
            bus.IN_DATA = 8'($urandom);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (pulse_q.size() == 0 && ready_q.size() == 0 &&
                accept_q.size() == 0 && done_q.size() == 0) break;
            @(negedge Clock); #1;
        end
        check("queues_drained",
              pulse_q.size() + ready_q.size() + accept_q.size() + done_q.size(), 0);
    endtask

    // Monitor: compares every observable event against the queued predictions.
    initial begin
        logic       en_prev, rdy_prev, done_prev;
        int         en_start, r;
        logic [7:0] cur_data;
        pulse_t     p;
        en_prev = 1'b0; rdy_prev = 1'b0; done_prev = 1'b0;
        en_start = -1; cur_data = 8'h00;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                en_prev = 1'b0; rdy_prev = 1'b0; done_prev = 1'b0; en_start = -1;
            end else begin
                if (lcd_en && !en_prev) begin
                    check("pulse_expected", int'(pulse_q.size() > 0), 1);
                    if (pulse_q.size() > 0) begin
                        p = pulse_q.pop_front();
                        n_pulse++;
                        $display("pulse %0d: rs=%0b data=0x%02h at cycle %0d (predicted %0d)",
                                 n_pulse, lcd_rs, lcd_data, cyc_now, p.rise);
                        check("pulse_cycle", cyc_now, p.rise);
                        check("pulse_rs", int'(lcd_rs), int'(p.rs));
                        check("pulse_data", int'(lcd_data), int'(p.data));
                        check("lcd_rw", int'(lcd_rw), 0);
                        cur_data = p.data;
                    end
                    en_start = cyc_now;
                end
                if (lcd_en && en_prev) check("data_hold_en", int'(lcd_data), int'(cur_data));
                if (!lcd_en && en_prev && en_start >= 0) check("en_width", cyc_now - en_start, P_EN);
                if (bus.IN_READY && !rdy_prev) begin
                    check("ready_expected", int'(ready_q.size() > 0), 1);
                    if (ready_q.size() > 0) begin
                        r = ready_q.pop_front();
                        check("ready_cycle", cyc_now, r);
                    end
                end
                if (init_done && !done_prev) begin
                    check("done_expected", int'(done_q.size() > 0), 1);
                    if (done_q.size() > 0) begin
                        r = done_q.pop_front();
                        check("init_done_cycle", cyc_now, r);
                    end
                end
                if (bus.IN_VALID && bus.IN_READY) begin
                    check("accept_expected", int'(accept_q.size() > 0), 1);
                    if (accept_q.size() > 0) begin
                        r = accept_q.pop_front();
                        check("accept_cycle", cyc_now, r);
                    end
                end
                if (bus.IN_READY) check("ready_needs_init_done", int'(init_done), 1);
                en_prev   = lcd_en;
                rdy_prev  = bus.IN_READY;
                done_prev = init_done;
            end
        end
    end

    // Stimulus
    initial begin
        logic       rs;
        logic [7:0] d;
        bit         got;
        bus.IN_VALID = 1'b0;
        bus.IN_RS    = 1'b0;
        bus.IN_DATA  = 8'h00;
        Reset        = 1'b1;
        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        push_init();
        @(negedge Clock);
        check_reset_values();

        // Byte offered long before init completes, then back-to-back bytes.
        do begin @(posedge Clock); #1; end while (cyc_now < 20);
        send(1'b1, 8'h41);
        send(1'b1, 8'h42);
        gap(2);
        send(1'b0, 8'h01);
        gap(1);
        send(1'b1, 8'h01);
        send(1'b0, 8'h02);

        for (int n = 0; n < 24; n++) begin
            gap($urandom_range(0, 3));
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       d = 8'h01;
                1:       d = 8'h02;
                default: d = 8'($urandom);
            endcase
            send(rs, d);
        end
        drain();

        // Reset while EN is high: outputs clear next cycle, init restarts.
        gap(1);
        send(1'b1, 8'h77);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge Clock);
            if (lcd_en) got = 1'b1;
        end
        check("en_seen_before_reset", int'(got), 1);
        @(posedge Clock); #1;
        Reset = 1'b1;
        pulse_q.delete(); ready_q.delete(); accept_q.delete(); done_q.delete();
        @(posedge Clock); #1;
        Reset = 1'b0;
        push_init();
        @(negedge Clock);
        check_reset_values();
        @(posedge Clock); #1;
        send(1'b0, 8'h0C);
        send(1'b1, 8'h5A);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc_now);
        $fatal(1, "watchdog");
    end

endmodule
